// File: rtl/audio_pkg.sv
// Shared constants and state type for the audio capture/playback blocks.
package audio_pkg;

  localparam int SAMPLE_LEN = 24322;
  localparam int SAMPLE_W   = 8;
  localparam int FREQ_W     = 16;
  localparam int ACC_W      = 19;
  localparam int PTR_W      = $clog2(SAMPLE_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    ARMED = 2'd2
  } rec_state_t;

  // Distance of an offset-binary sample from the 0x80 midpoint.
  function automatic logic [SAMPLE_W-1:0] abs_offset(input logic [SAMPLE_W-1:0] s);
    return (s >= 8'h80) ? (s - 8'h80) : (8'h80 - s);
  endfunction

endpackage

// File: rtl/audio_phase_acc.sv
// Free-running phase accumulator; tick_o marks each MSB 1->0 wrap.
module audio_phase_acc
  import audio_pkg::*;
#(
  parameter int ACC_W = audio_pkg::ACC_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic              tick_o
);

  logic [ACC_W-1:0] acc_reg;
  logic             msb_d_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_reg   <= '0;
      msb_d_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_reg + ACC_W'(freq_i);
      msb_d_reg <= acc_reg[ACC_W-1];
    end
  end

  assign tick_o = msb_d_reg & ~acc_reg[ACC_W-1];

endmodule

// File: rtl/audio_sample_rec.sv
// Tick-paced audio sample recorder into a simple dual-port RAM.
// Define AUDIO_REC_TRIG_EN to hold off capture until the input exceeds THRESH.
module audio_sample_rec
  import audio_pkg::*;
#(
  parameter int DEPTH  = SAMPLE_LEN,
  parameter int ACC_W  = audio_pkg::ACC_W,
  parameter int THRESH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [FREQ_W-1:0]   freq_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [PTR_W-1:0]    len_o,
  input  logic [PTR_W-1:0]    rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);

  rec_state_t          state_reg, state_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    len_reg, len_next;
  logic                done_reg, done_next;
  logic [SAMPLE_W-1:0] rd_data_reg;
  logic                tick;
  logic                capture;
  logic                wr_en;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  audio_phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .freq_i (freq_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      len_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      len_reg    <= len_next;
      done_reg   <= done_next;
    end
  end

  // start wins over everything; a tick coinciding with stop is stored before stopping.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    len_next    = len_reg;
    done_next   = 1'b0;
    capture     = 1'b0;
    wr_en       = 1'b0;
    if (start_i) begin
      wr_ptr_next = '0;
      len_next    = '0;
`ifdef AUDIO_REC_TRIG_EN
      state_next  = ARMED;
`else
      state_next  = REC;
`endif
    end else begin
      case (state_reg)
        REC:     capture = tick;
`ifdef AUDIO_REC_TRIG_EN
        ARMED:   capture = tick && (int'(abs_offset(sample_i)) > THRESH);
`endif
        default: capture = 1'b0;
      endcase
      if (capture) begin
        wr_en       = ~rst_i;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        len_next    = len_reg + PTR_W'(1);
        state_next  = REC;
        if (wr_ptr_reg == LAST_ADDR) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      if (stop_i && (state_reg != IDLE)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_reg] <= sample_i;
  end

  // Separate read register keeps read-first behaviour on address collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_reg <= '0;
    else       rd_data_reg <= mem[rd_addr_i];
  end

  assign busy_o    = (state_reg != IDLE);
  assign done_o    = done_reg;
  assign len_o     = len_reg;
  assign rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_audio_sample_rec.sv
// Scoreboard bench for audio_sample_rec: done_o and read data checked by a monitor.
module tb_audio_sample_rec;
  import audio_pkg::*;

  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [FREQ_W-1:0]   freq = 16'h8000;
  logic [SAMPLE_W-1:0] sample = '0;
  logic                busy, done;
  logic [PTR_W-1:0]    len;
  logic [PTR_W-1:0]    rd_addr = '0;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_done_q [$];
  logic [31:0] exp_rd_q   [$];

  always #5 clk = ~clk;

  audio_sample_rec #(.DEPTH(DEPTH), .ACC_W(19), .THRESH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .stop_i    (stop),
    .freq_i    (freq),
    .sample_i  (sample),
    .busy_o    (busy),
    .done_o    (done),
    .len_o     (len),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Clock edges since reset release; with freq=0x8000 a tick is live whenever cyc%16==0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    logic req_now;
    logic [31:0] e;
    req_now = rd_req;
    #1;
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) check("unexpected_done", 32'(len), 32'hDEAD);
      else begin
        e = exp_done_q.pop_front();
        check("done_len", 32'(len), e);
      end
    end
    if (req_now) begin
      if (exp_rd_q.size() == 0) check("rd_queue_empty", 32'(rd_data), 32'hDEAD);
      else begin
        e = exp_rd_q.pop_front();
        $display("read addr %0d data %0h expected %0h", rd_addr, rd_data, e);
        check("rd_data", 32'(rd_data), e);
      end
    end
  end

  task automatic wait_phase(input int ph);
    do @(negedge clk); while ((cyc % 16) != ph);
  endtask

  task automatic tick_sample(input logic [7:0] v);
    do @(negedge clk); while (((cyc % 16) != 0) || (cyc < 16));
    sample = v;
  endtask

  task automatic pulse_start();
    wait_phase(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    wait_phase(8);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = PTR_W'(addr);
    rd_req  = 1'b1;
    exp_rd_q.push_back(32'(exp));
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_len", 32'(len), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    rst = 1'b0;

    // Full capture: sample k on tick k, DEPTH entries then auto-stop.
    exp_done_q.push_back(32'(DEPTH));
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < DEPTH; k++) tick_sample(8'(k));
    repeat (3) @(negedge clk);
    check("full_busy_low", 32'(busy), 0);
    check("full_len_held", 32'(len), DEPTH);
    for (int k = 0; k < DEPTH; k++) rd(k, 8'(k));

    // Stop coincides with the 5th tick: that sample is still stored.
    exp_done_q.push_back(32'd5);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      tick_sample(8'hA0 + 8'(k));
      if (k == 4) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_len", 32'(len), 5);
    rd(4, 8'hA4);
    rd(0, 8'hA0);
    rd(5, 8'h05);

    // start+stop together restarts without a done pulse.
    pulse_start();
    tick_sample(8'h11);
    tick_sample(8'h22);
    wait_phase(4);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("restart_busy", 32'(busy), 1);
    check("restart_len", 32'(len), 0);
    exp_done_q.push_back(32'd1);
    tick_sample(8'h33);
    pulse_stop();
    repeat (2) @(negedge clk);
    rd(0, 8'h33);
    rd(1, 8'h22);

    // stop in IDLE is ignored.
    pulse_stop();
    repeat (2) @(negedge clk);
    check("idle_stop_len", 32'(len), 1);
    check("idle_stop_busy", 32'(busy), 0);

    // Same-cycle read and write of address 0 returns the old contents.
    exp_done_q.push_back(32'd1);
    pulse_start();
    tick_sample(8'h5A);
    rd_addr = '0;
    rd_req  = 1'b1;
    exp_rd_q.push_back(32'h33);
    @(negedge clk);
    rd_req = 1'b0;
    pulse_stop();
    repeat (2) @(negedge clk);
    rd(0, 8'h5A);

    // Reset in the middle of a capture: outputs clear, no done pulse.
    pulse_start();
    tick_sample(8'h44);
    tick_sample(8'h45);
    wait_phase(4);
    rst     = 1'b1;
    rd_addr = '0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_len", 32'(len), 0);
    check("midrst_rd_data", 32'(rd_data), 0);
    @(negedge clk);
    check("midrst_done2", 32'(done), 0);

    // freq=0: no ticks, so nothing is captured.
    freq = 16'h0000;
    rst  = 1'b0;
    exp_done_q.push_back(32'd0);
    pulse_start();
    repeat (40) @(negedge clk);
    check("freq0_len", 32'(len), 0);
    pulse_stop();
    repeat (2) @(negedge clk);
    freq = 16'h8000;
    do_reset();

`ifdef AUDIO_REC_TRIG_EN
    // Sub-threshold samples are skipped while ARMED.
    exp_done_q.push_back(32'd1);
    pulse_start();
    for (int k = 0; k < 3; k++) tick_sample(8'h84);
    @(negedge clk);
    check("armed_busy", 32'(busy), 1);
    check("armed_len", 32'(len), 0);
    tick_sample(8'h90);
    pulse_stop();
    repeat (2) @(negedge clk);
    rd(0, 8'h90);
`else
    // Without the trigger, the first tick after start is captured.
    exp_done_q.push_back(32'd1);
    pulse_start();
    check("direct_rec_busy", 32'(busy), 1);
    tick_sample(8'h84);
    pulse_stop();
    repeat (2) @(negedge clk);
    rd(0, 8'h84);
`endif

    repeat (4) @(negedge clk);
    check("done_queue_drained", 32'(exp_done_q.size()), 0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
